// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the integer clock divider.
// Holds the active divide ratio, accepts new ratios over a valid/ready
// handshake and applies ratio changes and enable/disable requests only at a
// divided-period boundary, so the divided clock never shows a runt period.
// All outputs are flops loaded from the next-state values.

module clk_div_ctrl #(
    parameter int CW      = 8,
    parameter int DEF_DIV = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_div,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic [CW-1:0] div_cur,
    output logic          clk_out,
    output logic          div_tick,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam logic [CW-1:0] DIV_RESET = CW'(DEF_DIV);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DIV_MIN   = CW'(2);

    // current state registers
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] div_act_r;
    logic [CW-1:0] div_pend_r;
    logic          pend_flag_r;

    // next-state values
    state_t        state_s;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] div_act_s;
    logic [CW-1:0] div_pend_s;
    logic          pend_flag_s;

    // handshake and period decode
    logic          xfer_s;
    logic          div_ok_s;
    logic          good_xfer_s;
    logic          bad_xfer_s;
    logic          boundary_s;
    logic [CW-1:0] cnt_wrap_s;
    logic          run_s;
    logic          clk_out_s;
    logic          div_tick_s;

    // Transfer qualification and counter wrap decode for the current cycle
    always_comb begin
        xfer_s      = cfg_valid && cfg_ready;
        div_ok_s    = (cfg_div >= DIV_MIN);
        good_xfer_s = xfer_s && div_ok_s;
        bad_xfer_s  = xfer_s && !div_ok_s;
        // div_act_r is never below 2, so the subtraction cannot wrap
        boundary_s  = (cnt_r == (div_act_r - CNT_ONE));
        if (boundary_s) begin
            cnt_wrap_s = CNT_ZERO;
        end else begin
            cnt_wrap_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state logic: ratio and run changes land only on period boundaries
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        div_act_s   = div_act_r;
        div_pend_s  = div_pend_r;
        pend_flag_s = pend_flag_r;

        case (state_r)
            ST_IDLE: begin
                cnt_s       = CNT_ZERO;
                pend_flag_s = 1'b0;
                // a divisor offered together with en is used by the first period
                if (good_xfer_s) begin
                    div_act_s = cfg_div;
                end else begin
                    div_act_s = div_act_r;
                end
                if (en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                cnt_s = cnt_wrap_s;
                if (boundary_s) begin
                    // a transfer on the closing cycle is applied immediately
                    if (good_xfer_s) begin
                        div_act_s = cfg_div;
                    end else begin
                        div_act_s = div_act_r;
                    end
                    if (en) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (good_xfer_s) begin
                    div_pend_s  = cfg_div;
                    pend_flag_s = 1'b1;
                    state_s     = ST_PEND;
                end else if (!en) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_RUN;
                end
            end

            ST_PEND: begin
                cnt_s = cnt_wrap_s;
                if (boundary_s) begin
                    // pending divisor is applied even when en has fallen
                    div_act_s   = div_pend_r;
                    pend_flag_s = 1'b0;
                    if (en) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_PEND;
                end
            end

            ST_STOP: begin
                cnt_s = cnt_wrap_s;
                if (boundary_s) begin
                    // newest offer wins over an older pending divisor
                    if (good_xfer_s) begin
                        div_act_s = cfg_div;
                    end else if (pend_flag_r) begin
                        div_act_s = div_pend_r;
                    end else begin
                        div_act_s = div_act_r;
                    end
                    pend_flag_s = 1'b0;
                    if (en) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    if (good_xfer_s) begin
                        div_pend_s  = cfg_div;
                        pend_flag_s = 1'b1;
                    end else begin
                        div_pend_s  = div_pend_r;
                        pend_flag_s = pend_flag_r;
                    end
                    // re-enable mid-period resumes counting undisturbed;
                    // a pending divisor then locks the handshake like PEND
                    if (en) begin
                        if (good_xfer_s || pend_flag_r) begin
                            state_s = ST_PEND;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_STOP;
                    end
                end
            end

            default: begin
                state_s     = ST_IDLE;
                cnt_s       = CNT_ZERO;
                div_act_s   = DIV_RESET;
                div_pend_s  = DIV_RESET;
                pend_flag_s = 1'b0;
            end
        endcase
    end

    // Output decode from next-state so the output flops line up with cnt
    always_comb begin
        run_s = (state_s != ST_IDLE);
        if (run_s) begin
            clk_out_s  = (cnt_s < (div_act_s >> 1));
            div_tick_s = (cnt_s == (div_act_s - CNT_ONE));
        end else begin
            clk_out_s  = 1'b0;
            div_tick_s = 1'b0;
        end
    end

    // State, datapath and registered output update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            div_act_r   <= DIV_RESET;
            div_pend_r  <= DIV_RESET;
            pend_flag_r <= 1'b0;
            clk_out     <= 1'b0;
            div_tick    <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            div_act_r   <= div_act_s;
            div_pend_r  <= div_pend_s;
            pend_flag_r <= pend_flag_s;
            clk_out     <= clk_out_s;
            div_tick    <= div_tick_s;
            busy        <= run_s;
            cfg_ready   <= (state_s != ST_PEND);
            cfg_err     <= bad_xfer_s;
        end
    end

    assign div_cur = div_act_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed stimulus, a cycle-level behavioural
// model of the divided period checked every cycle, plus literal waveform
// expectations for the key scenarios.

module tb_clk_div_ctrl;

    localparam int CW      = 8;
    localparam int DEF_DIV = 3;

    logic          clk;
    logic          reset;
    logic          en;
    logic          cfg_valid;
    logic [CW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;
    logic [CW-1:0] div_cur;
    logic          clk_out;
    logic          div_tick;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // behavioural model: position inside the period, divisor, pending offer
    bit m_started = 1'b0;
    bit m_run, m_wind, m_lock, m_pend_has, m_err;
    int m_pos, m_div, m_pend_val;

    clk_div_ctrl #(.CW(CW), .DEF_DIV(DEF_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_cur   (div_cur),
        .clk_out   (clk_out),
        .div_tick  (div_tick),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        bit xfer, good, b;
        if (reset) begin
            m_run = 1'b0; m_pos = 0; m_div = DEF_DIV;
            m_pend_has = 1'b0; m_pend_val = 0;
            m_lock = 1'b0; m_wind = 1'b0; m_err = 1'b0;
            m_started = 1'b1;
            return;
        end
        xfer  = cfg_valid && !m_lock;
        good  = xfer && (cfg_div >= 2);
        m_err = xfer && (cfg_div < 2);
        if (!m_run) begin
            if (good) m_div = cfg_div;
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            b = (m_pos == m_div - 1);
            if (good) begin
                m_pend_has = 1'b1;
                m_pend_val = cfg_div;
                if (!b && !m_wind) m_lock = 1'b1;
            end
            if (b) begin
                if (m_pend_has) m_div = m_pend_val;
                m_pend_has = 1'b0;
                m_lock = 1'b0;
                m_wind = 1'b0;
                m_pos = 0;
                if (!en) m_run = 1'b0;
            end else begin
                m_pos++;
                if (!m_lock) begin
                    if (!en) m_wind = 1'b1;
                    else if (m_wind) begin
                        m_wind = 1'b0;
                        if (m_pend_has) m_lock = 1'b1;
                    end
                end
            end
        end
    endtask

    // compare process: model update on each edge, DUT check just after it
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (m_started) begin
                chk("m_clk_out",   clk_out,   m_run && (m_pos < m_div / 2));
                chk("m_div_tick",  div_tick,  m_run && (m_pos == m_div - 1));
                chk("m_busy",      busy,      m_run);
                chk("m_cfg_ready", cfg_ready, !m_lock);
                chk("m_cfg_err",   cfg_err,   m_err);
                chk("m_div_cur",   div_cur,   m_div);
            end
        end
    end

    // collect n consecutive negedge samples, oldest in the highest used bit
    task automatic sample(input int n, output logic [15:0] cv, output logic [15:0] tv,
                          output logic [15:0] rv, output logic [15:0] bv);
        cv = '0; tv = '0; rv = '0; bv = '0;
        for (int i = 0; i < n; i++) begin
            cv = {cv[14:0], clk_out};
            tv = {tv[14:0], div_tick};
            rv = {rv[14:0], cfg_ready};
            bv = {bv[14:0], busy};
            @(negedge clk);
        end
    endtask

    // move to the next negedge where div_tick is high, bounded
    task automatic wait_tick(input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (div_tick !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (div_tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: got no tick within %0d cycles", maxc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] cv, tv, rv, bv;
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_div_cur", div_cur, 32'd3);
        chk("rst_ready",   cfg_ready, 32'd1);
        chk("rst_busy",    busy, 32'd0);
        chk("rst_clk_out", clk_out, 32'd0);

        // default divide-by-3
        en = 1'b1;
        @(negedge clk);
        sample(9, cv, tv, rv, bv);
        chk("div3_clk",  cv, 16'b0000000_100100100);
        chk("div3_tick", tv, 16'b0000000_001001001);

        // offer 4 at cnt=0 of a div-3 period: held pending for two cycles
        cfg_valid = 1'b1; cfg_div = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        sample(10, cv, tv, rv, bv);
        chk("pend4_ready", rv, 16'b000000_0011111111);
        chk("pend4_clk",   cv, 16'b000000_0011001100);

        // offer 5 on the boundary cycle: applied at once, never pending
        wait_tick(10);
        cfg_valid = 1'b1; cfg_div = 8'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        sample(10, cv, tv, rv, bv);
        chk("bnd5_clk",   cv, 16'b000000_1100011000);
        chk("bnd5_tick",  tv, 16'b000000_0000100001);
        chk("bnd5_ready", rv, 16'b000000_1111111111);
        chk("bnd5_div",   div_cur, 32'd5);

        // back to 3, then illegal divisors 1 and 0
        wait_tick(10);
        cfg_valid = 1'b1; cfg_div = 8'd3;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("err1_pulse", cfg_err, 32'd1);
        @(negedge clk);
        chk("err1_clear", cfg_err, 32'd0);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("err0_pulse", cfg_err, 32'd1);
        chk("err0_div",   div_cur, 32'd3);
        @(negedge clk);
        chk("err0_clear", cfg_err, 32'd0);

        // div 6, drop en at cnt=1: finish the period then go idle
        wait_tick(10);
        cfg_valid = 1'b1; cfg_div = 8'd6;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        sample(6, cv, tv, rv, bv);
        chk("stop6_clk",  cv, 16'b0000000000_100000);
        chk("stop6_tick", tv, 16'b0000000000_000100);
        chk("stop6_busy", bv, 16'b0000000000_111100);

        // drop en at cnt=1, raise again at cnt=3: no disturbance
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        sample(8, cv, tv, rv, bv);
        chk("resume_busy", bv, 16'b00000000_11111111);
        chk("resume_tick", tv, 16'b00000000_01000001);
        chk("resume_clk",  cv, 16'b00000000_00111000);

        // pending divisor with en falling: applied at the boundary, then idle
        cfg_valid = 1'b1; cfg_div = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0; en = 1'b0;
        sample(7, cv, tv, rv, bv);
        chk("pendoff_busy",  bv, 16'b000000000_1111100);
        chk("pendoff_ready", rv, 16'b000000000_0000011);
        chk("pendoff_div",   div_cur, 32'd2);

        // transfer and enable on the same idle edge: first period uses 5
        cfg_valid = 1'b1; cfg_div = 8'd5; en = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        sample(10, cv, tv, rv, bv);
        chk("idle5_clk", cv, 16'b000000_1100011000);

        // stopping with a new offer: applied when the period closes
        en = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("stoppend_ready", cfg_ready, 32'd1);
        sample(4, cv, tv, rv, bv);
        chk("stoppend_busy", bv, 16'b000000000000_1110);
        chk("stoppend_div",  div_cur, 32'd4);

        // reset in the middle of a pending change (div 4, pending 7)
        en = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 8'd7;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("rstpend_ready_lo", cfg_ready, 32'd0);
        reset = 1'b1; en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rstpend_div",   div_cur, 32'd3);
        chk("rstpend_ready", cfg_ready, 32'd1);
        chk("rstpend_busy",  busy, 32'd0);
        chk("rstpend_tick",  div_tick, 32'd0);
        en = 1'b1;
        @(negedge clk);
        sample(9, cv, tv, rv, bv);
        chk("rstpend_clk3", cv, 16'b0000000_100100100);

        // reset wins over a same-edge transfer
        reset = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd9;
        @(negedge clk);
        reset = 1'b0; cfg_valid = 1'b0; en = 1'b0;
        chk("rstx_div",  div_cur, 32'd3);
        chk("rstx_busy", busy, 32'd0);
        repeat (3) @(negedge clk);
        chk("rstx_idle_clk", clk_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
